// File: rtl/alu_cmd_ctrl.sv
// Command sequencer between the UART byte stream and the system ALU: parses
// {command, A, B} frames, runs one ALU operation and streams the result back LSB byte first.
module alu_cmd_ctrl #(
    parameter int         WIDTH          = 8,
    parameter int         ALU_FUN_WIDTH  = 4,
    parameter logic [3:0] CMD_TAG        = 4'hA,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter int         ALU_WAIT_MAX   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_rx_data,
    input  logic                     i_rx_valid,
    output logic                     o_alu_en,
    output logic [WIDTH-1:0]         o_alu_a,
    output logic [WIDTH-1:0]         o_alu_b,
    output logic [ALU_FUN_WIDTH-1:0] o_alu_func,
    input  logic                     i_alu_valid,
    input  logic [WIDTH-1:0]         i_alu_out,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic                     o_busy,
    output logic                     o_frame_err,
    output logic                     o_overrun
);

    localparam int NB   = WIDTH / 8;
    localparam int CW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int TMAX = (TIMEOUT_CYCLES > ALU_WAIT_MAX) ? TIMEOUT_CYCLES : ALU_WAIT_MAX;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WAIT,
        S_SEND
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [CW-1:0]            r_byte_cnt;
    logic [TW-1:0]            r_timer;
    logic [ALU_FUN_WIDTH-1:0] r_func;
    logic [WIDTH-1:0]         r_a;
    logic [WIDTH-1:0]         r_b;
    logic [WIDTH-1:0]         r_result;
    logic [WIDTH-1:0]         r_alu_a;
    logic [WIDTH-1:0]         r_alu_b;
    logic [ALU_FUN_WIDTH-1:0] r_alu_func;
    logic                     r_frame_err;
    logic                     r_overrun;

    logic                     w_byte_acc;
    logic                     w_last_byte;
    logic                     w_abort;
    logic                     w_bad_tag;
    logic                     w_drop;
    logic                     w_capture;
    logic                     w_tx_fire;
    logic [WIDTH-1:0]         w_src;
    logic [WIDTH-1:0]         w_shift_in;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A byte strobe takes priority over an expiring inter-byte timer.
    always_comb begin
        w_next_state = r_state;
        w_byte_acc   = 1'b0;
        w_last_byte  = 1'b0;
        w_abort      = 1'b0;
        w_bad_tag    = 1'b0;
        w_drop       = 1'b0;
        w_capture    = 1'b0;
        w_tx_fire    = 1'b0;
        w_src        = (r_state == S_GET_A) ? r_a : r_b;
        w_shift_in   = (w_src >> 8) | (WIDTH'(i_rx_data) << (WIDTH - 8));
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data[7:4] == CMD_TAG) begin
                        w_next_state = S_GET_A;
                    end else begin
                        w_bad_tag = 1'b1;
                    end
                end
            end
            S_GET_A, S_GET_B: begin
                if (i_rx_valid) begin
                    w_byte_acc = 1'b1;
                    if (r_byte_cnt == CW'(NB - 1)) begin
                        w_last_byte = 1'b1;
                        if (r_state == S_GET_A) begin
                            w_next_state = S_GET_B;
                        end else begin
                            w_next_state = S_EXEC;
                        end
                    end
                end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_EXEC: begin
                w_drop       = i_rx_valid;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_drop = i_rx_valid;
                if (i_alu_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_SEND;
                end else if (r_timer == TW'(ALU_WAIT_MAX - 1)) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_SEND: begin
                w_drop = i_rx_valid;
                if (i_tx_ready) begin
                    w_tx_fire = 1'b1;
                    if (r_byte_cnt == CW'(NB - 1)) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_byte_cnt  <= '0;
            r_timer     <= '0;
            r_func      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_func  <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad_tag | w_abort;
            r_overrun   <= w_drop;

            if ((w_next_state != r_state) || w_byte_acc) begin
                r_timer <= '0;
            end else if ((r_state == S_GET_A) || (r_state == S_GET_B) || (r_state == S_WAIT)) begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_byte_acc || w_tx_fire) begin
                r_byte_cnt <= (r_byte_cnt == CW'(NB - 1)) ? '0 : r_byte_cnt + CW'(1);
            end else if (w_next_state == S_IDLE) begin
                r_byte_cnt <= '0;
            end

            if ((r_state == S_IDLE) && (w_next_state == S_GET_A)) begin
                r_func <= i_rx_data[ALU_FUN_WIDTH-1:0];
            end

            if (w_abort) begin
                r_a <= '0;
                r_b <= '0;
            end else if (w_byte_acc && (r_state == S_GET_A)) begin
                r_a <= w_shift_in;
            end else if (w_byte_acc && (r_state == S_GET_B)) begin
                r_b <= w_shift_in;
            end

            // ALU operands only change on the edge into EXEC, so they hold between operations.
            if (w_byte_acc && w_last_byte && (r_state == S_GET_B)) begin
                r_alu_a    <= r_a;
                r_alu_b    <= w_shift_in;
                r_alu_func <= r_func;
            end

            if (w_capture) begin
                r_result <= i_alu_out;
            end else if (w_tx_fire) begin
                r_result <= r_result >> 8;
            end
        end
    end

    assign o_alu_en    = (r_state == S_EXEC);
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_func  = r_alu_func;
    assign o_tx_valid  = (r_state == S_SEND);
    assign o_tx_data   = r_result[7:0];
    assign o_busy      = (r_state != S_IDLE);
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Testbench for alu_cmd_ctrl: directed frames plus random traffic, with a behavioural
// ALU responder, a TX sink and a per-cycle checker fed by an expected-transaction queue.
module tb_alu_cmd_ctrl;

    localparam int TIMEOUT = 1000;
    localparam int WAITMAX = 4;

    logic       clock    = 1'b0;
    logic       resetN   = 1'b0;
    logic [7:0] rxData   = 8'h00;
    logic       rxValid  = 1'b0;
    logic       aluEn;
    logic [7:0] aluA;
    logic [7:0] aluB;
    logic [3:0] aluFunc;
    logic       aluValid = 1'b0;
    logic [7:0] aluOut   = 8'h00;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady  = 1'b1;
    logic       busy;
    logic       frameErr;
    logic       overrun;

    int          errors     = 0;
    int          checks     = 0;
    logic [19:0] expOps[$];
    logic [7:0]  expTx[$];
    int          aluLatency = 1;
    bit          stallTx    = 1'b0;
    bit          randReady  = 1'b0;
    int          errPulses  = 0;
    int          ovrPulses  = 0;
    int          txCount    = 0;
    logic [7:0]  lastTx     = 8'h00;
    bit          prevStall  = 1'b0;
    bit          prevEn     = 1'b0;
    logic [7:0]  prevData   = 8'h00;
    logic [19:0] compOp;

    alu_cmd_ctrl dut (
        .i_clk       (clock),
        .i_rst       (resetN),
        .i_rx_data   (rxData),
        .i_rx_valid  (rxValid),
        .o_alu_en    (aluEn),
        .o_alu_a     (aluA),
        .o_alu_b     (aluB),
        .o_alu_func  (aluFunc),
        .i_alu_valid (aluValid),
        .i_alu_out   (aluOut),
        .o_tx_data   (txData),
        .o_tx_valid  (txValid),
        .i_tx_ready  (txReady),
        .o_busy      (busy),
        .o_frame_err (frameErr),
        .o_overrun   (overrun)
    );

    always #5 clock = ~clock;

    // Reference ALU: unsigned, truncated to 8 bits; unused codes get an arbitrary distinct function.
    function automatic logic [7:0] aluRef(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return p[7:0];
            default: return a + b + {4'h0, f};
        endcase
    endfunction

    function automatic logic [63:0] outVector();
        return {31'b0, aluEn, aluA, aluB, aluFunc, txData, txValid, busy, frameErr, overrun};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        @(negedge clock);
        rxValid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clock);
        #1;
    endtask

    task automatic waitIdle(input string name, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, busy, 0);
    endtask

    task automatic waitTxValid(input string name, input int bound);
        int n = 0;
        while (!txValid && n < bound) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, txValid, 1);
    endtask

    // Latency 1..WAITMAX produces a result; anything else is expected to end in a frame error.
    task automatic sendFrame(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                             input int lat, input int gap);
        expOps.push_back({f, a, b});
        if (lat >= 1 && lat <= WAITMAX) expTx.push_back(aluRef(f, a, b));
        aluLatency = lat;
        applyStimulus({4'hA, f});
        repeat (gap) @(negedge clock);
        applyStimulus(a);
        repeat (gap) @(negedge clock);
        applyStimulus(b);
        checkOutput("alu_en_timing", aluEn, 1);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #2;
            txReady = stallTx ? 1'b0 : (randReady ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    initial begin
        logic [7:0] res;
        int lat;
        forever begin
            @(negedge clock);
            if (resetN && aluEn) begin
                res = aluRef(aluFunc, aluA, aluB);
                lat = aluLatency;
                repeat (lat) @(negedge clock);
                aluOut   = res;
                aluValid = 1'b1;
                @(negedge clock);
                aluValid = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (!resetN) begin
            prevStall = 1'b0;
            prevEn    = 1'b0;
        end else begin
            if (aluEn) begin
                checkOutput("alu_en_single", prevEn, 0);
                if (expOps.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL alu_en_unexpected: got operation func=%0h a=%0h b=%0h, expected none",
                             aluFunc, aluA, aluB);
                end else begin
                    compOp = expOps.pop_front();
                    checkOutput("alu_func", aluFunc, compOp[19:16]);
                    checkOutput("alu_a", aluA, compOp[15:8]);
                    checkOutput("alu_b", aluB, compOp[7:0]);
                end
            end
            if (prevStall) begin
                checkOutput("tx_hold_valid", txValid, 1);
                checkOutput("tx_hold_data", txData, prevData);
            end
            if (txValid && txReady) begin
                if (expTx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL tx_unexpected: got byte 0x%0h, expected none", txData);
                end else begin
                    checkOutput("tx_data", txData, expTx.pop_front());
                end
                lastTx = txData;
                txCount++;
            end
            if (frameErr) errPulses++;
            if (overrun) ovrPulses++;
            prevStall = txValid && !txReady;
            prevData  = txData;
            prevEn    = aluEn;
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int e0;
        int o0;
        int t0;
        int n;

        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset_state", outVector(), 0);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);

        // Basic add frame.
        sendFrame(4'h0, 8'h05, 8'h03, 1, 0);
        waitIdle("t1_idle", 50);
        settle();
        checkOutput("t1_result", lastTx, 8'h08);

        // Bad command tag, then a good frame.
        e0 = errPulses;
        applyStimulus(8'h5F);
        settle();
        checkOutput("t2_bad_tag_err", errPulses - e0, 1);
        checkOutput("t2_busy", busy, 0);
        sendFrame(4'h3, 8'h0C, 8'h30, 2, 1);
        waitIdle("t2_idle", 50);
        settle();
        checkOutput("t2_result", lastTx, 8'h3C);

        // Inter-byte timeout: the error appears after TIMEOUT idle cycles.
        e0 = errPulses;
        applyStimulus(8'hA1);
        applyStimulus(8'h09);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frameErr && n < TIMEOUT + 20);
        checkOutput("t3_timeout_cycles", n, TIMEOUT);
        settle();
        checkOutput("t3_timeout_err", errPulses - e0, 1);
        checkOutput("t3_busy", busy, 0);
        sendFrame(4'h1, 8'h09, 8'h04, 1, 0);
        waitIdle("t3_idle", 50);
        settle();
        checkOutput("t3_result", lastTx, 8'h05);

        // A byte landing on the very cycle the timer expires is accepted.
        e0 = errPulses;
        expOps.push_back({4'h2, 8'h09, 8'h0C});
        expTx.push_back(8'h08);
        aluLatency = 1;
        applyStimulus(8'hA2);
        applyStimulus(8'h09);
        repeat (TIMEOUT - 1) @(negedge clock);
        applyStimulus(8'h0C);
        checkOutput("t3_edge_alu_en", aluEn, 1);
        waitIdle("t3_edge_idle", 50);
        settle();
        checkOutput("t3_edge_no_err", errPulses - e0, 0);
        checkOutput("t3_edge_result", lastTx, 8'h08);

        // TX back-pressure for 20 cycles.
        stallTx = 1'b1;
        sendFrame(4'h4, 8'h5A, 8'h0F, 2, 0);
        waitTxValid("t4_tx_valid", 20);
        repeat (20) @(negedge clock);
        checkOutput("t4_stall_valid", txValid, 1);
        checkOutput("t4_stall_data", txData, 8'h55);
        t0 = txCount;
        stallTx = 1'b0;
        waitIdle("t4_idle", 20);
        settle();
        checkOutput("t4_one_byte", txCount - t0, 1);
        checkOutput("t4_result", lastTx, 8'h55);

        // RX byte while waiting for the ALU.
        o0 = ovrPulses;
        sendFrame(4'h5, 8'h0C, 8'h0D, 3, 0);
        @(negedge clock);
        applyStimulus(8'h77);
        waitIdle("t5_wait_idle", 50);
        settle();
        checkOutput("t5_wait_overrun", ovrPulses - o0, 1);
        checkOutput("t5_wait_result", lastTx, 8'h9C);

        // RX byte while a TX byte is pending.
        o0 = ovrPulses;
        stallTx = 1'b1;
        sendFrame(4'h1, 8'h03, 8'h05, 1, 0);
        waitTxValid("t5_send_valid", 20);
        applyStimulus(8'h77);
        settle();
        checkOutput("t5_send_overrun", ovrPulses - o0, 1);
        checkOutput("t5_send_still_valid", txValid, 1);
        stallTx = 1'b0;
        waitIdle("t5_send_idle", 20);
        settle();
        checkOutput("t5_send_result", lastTx, 8'hFE);

        // Reset in the middle of GET_B.
        applyStimulus(8'hA3);
        applyStimulus(8'h11);
        resetN = 1'b0;
        #1;
        checkOutput("t6_rst_get_b", outVector(), 0);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);

        // Reset in the middle of SEND; the pending byte is abandoned.
        stallTx = 1'b1;
        sendFrame(4'h2, 8'hF0, 8'h3C, 2, 0);
        waitTxValid("t6_tx_valid", 20);
        resetN = 1'b0;
        #1;
        checkOutput("t6_rst_send", outVector(), 0);
        void'(expTx.pop_back());
        @(negedge clock);
        stallTx = 1'b0;
        resetN  = 1'b1;
        @(negedge clock);
        sendFrame(4'h0, 8'hFF, 8'h02, 2, 0);
        waitIdle("t6_idle", 50);
        settle();
        checkOutput("t6_result", lastTx, 8'h01);

        // ALU response window: last allowed cycle, one too late, and only in EXEC.
        sendFrame(4'h3, 8'h81, 8'h18, WAITMAX, 0);
        waitIdle("t7_lat4_idle", 50);
        settle();
        checkOutput("t7_lat4_result", lastTx, 8'h99);
        e0 = errPulses;
        t0 = txCount;
        sendFrame(4'h0, 8'h01, 8'h01, WAITMAX + 1, 0);
        waitIdle("t7_lat5_idle", 50);
        settle();
        checkOutput("t7_lat5_err", errPulses - e0, 1);
        e0 = errPulses;
        sendFrame(4'h0, 8'h02, 8'h02, 0, 0);
        waitIdle("t7_lat0_idle", 50);
        settle();
        checkOutput("t7_lat0_err", errPulses - e0, 1);
        checkOutput("t7_no_tx", txCount - t0, 0);

        // Random frames with random gaps, ALU latency and TX readiness.
        randReady = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            sendFrame(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      $urandom_range(1, WAITMAX), $urandom_range(0, 2));
            waitIdle("rand_idle", 100);
        end
        randReady = 1'b0;
        settle();
        checkOutput("exp_ops_drained", expOps.size(), 0);
        checkOutput("exp_tx_drained", expTx.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
